// File: rtl/data_axi_bridge_pkg.sv
// Shared constants for the data-side AXI bridge: FSM encoding, access sizes and
// the fixed single-beat AXI burst attributes applied by the wrapper.
package data_axi_bridge_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_RD_A = 3'd1;
   localparam logic [2:0] ST_RD_D = 3'd2;
   localparam logic [2:0] ST_WR_A = 3'd3;
   localparam logic [2:0] ST_WR_B = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;

   localparam logic [2:0] SZ_BYTE = 3'd0;
   localparam logic [2:0] SZ_HALF = 3'd1;
   localparam logic [2:0] SZ_WORD = 3'd2;

   localparam logic [7:0] LEN_SINGLE = 8'd0;
   localparam logic [1:0] BURST_INCR = 2'd1;

endpackage

// File: rtl/data_axi_bridge.sv
// Core data-port responder: turns each accepted request into one single-beat AXI
// read or write and returns an in-order data_ok pulse. One transaction in flight.
module data_axi_bridge
   import data_axi_bridge_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        req,
   input  logic        wr,
   input  logic [2:0]  size,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata,
   output logic [31:0] araddr,
   output logic [2:0]  arsize,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] axi_rdata,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] awaddr,
   output logic [2:0]  awsize,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] axi_wdata,
   output logic [3:0]  axi_wstrb,
   output logic        wvalid,
   input  logic        wready,
   input  logic        bvalid,
   output logic        bready
);

   logic [2:0]  r_state;
   logic [2:0]  w_state_nxt;
   logic [2:0]  r_size;
   logic [3:0]  r_wstrb;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic        r_aw_done;
   logic        r_w_done;

   logic w_accept;
   logic w_aw_hs;
   logic w_w_hs;
   logic w_aw_fin;
   logic w_w_fin;

   // Gated by resetn so no request is acknowledged while reset is asserted.
   assign w_accept = resetn && (r_state == ST_IDLE) && req;
   assign w_aw_hs  = awvalid && awready;
   assign w_w_hs   = wvalid && wready;
   assign w_aw_fin = r_aw_done || w_aw_hs;
   assign w_w_fin  = r_w_done || w_w_hs;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_state_nxt = wr ? ST_WR_A : ST_RD_A;
         ST_RD_A: if (arready) w_state_nxt = ST_RD_D;
         ST_RD_D: if (rvalid) w_state_nxt = ST_DONE;
         ST_WR_A: if (w_aw_fin && w_w_fin) w_state_nxt = ST_WR_B;
         ST_WR_B: if (bvalid) w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state   <= ST_IDLE;
         r_size    <= 3'd0;
         r_wstrb   <= 4'd0;
         r_addr    <= 32'd0;
         r_wdata   <= 32'd0;
         r_rdata   <= 32'd0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_size    <= size;
            r_wstrb   <= wstrb;
            r_addr    <= addr;
            r_wdata   <= wdata;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end
         // Per-channel completion lets AW and W finish in either order.
         if (w_aw_hs) r_aw_done <= 1'b1;
         if (w_w_hs) r_w_done <= 1'b1;
         if ((r_state == ST_RD_D) && rvalid) r_rdata <= axi_rdata;
      end
   end

   assign addr_ok   = w_accept;
   assign data_ok   = (r_state == ST_DONE);
   assign rdata     = r_rdata;
   assign araddr    = r_addr;
   assign arsize    = r_size;
   assign arvalid   = (r_state == ST_RD_A);
   assign rready    = (r_state == ST_RD_D);
   assign awaddr    = r_addr;
   assign awsize    = r_size;
   assign awvalid   = (r_state == ST_WR_A) && !r_aw_done;
   assign axi_wdata = r_wdata;
   assign axi_wstrb = r_wstrb;
   assign wvalid    = (r_state == ST_WR_A) && !r_w_done;
   assign bready    = (r_state == ST_WR_B);

endmodule

// File: tb/tb_data_axi_bridge.sv
// Bench for data_axi_bridge: directed and randomized single-beat transactions
// against a transaction-level expectation of handshakes, latency and rdata.
module tb_data_axi_bridge;

   logic        clk;
   logic        resetn;
   logic        req;
   logic        wr;
   logic [2:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;
   logic [31:0] araddr;
   logic [2:0]  arsize;
   logic        arvalid;
   logic        arready;
   logic [31:0] axi_rdata;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic [2:0]  awsize;
   logic        awvalid;
   logic        awready;
   logic [31:0] axi_wdata;
   logic [3:0]  axi_wstrb;
   logic        wvalid;
   logic        wready;
   logic        bvalid;
   logic        bready;

   int          n_tests;
   int          n_fail;
   logic [31:0] exp_rdata;

   data_axi_bridge dut (
      .clk       (clk),
      .resetn    (resetn),
      .req       (req),
      .wr        (wr),
      .size      (size),
      .wstrb     (wstrb),
      .addr      (addr),
      .wdata     (wdata),
      .addr_ok   (addr_ok),
      .data_ok   (data_ok),
      .rdata     (rdata),
      .araddr    (araddr),
      .arsize    (arsize),
      .arvalid   (arvalid),
      .arready   (arready),
      .axi_rdata (axi_rdata),
      .rvalid    (rvalid),
      .rready    (rready),
      .awaddr    (awaddr),
      .awsize    (awsize),
      .awvalid   (awvalid),
      .awready   (awready),
      .axi_wdata (axi_wdata),
      .axi_wstrb (axi_wstrb),
      .wvalid    (wvalid),
      .wready    (wready),
      .bvalid    (bvalid),
      .bready    (bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Read with ard cycles of arready stall and rd cycles before rvalid.
   task automatic do_read(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d,
                          input int ard, input int rd, input bit keep);
      req = 1'b1; wr = 1'b0; addr = a; size = sz;
      wstrb = 4'($urandom); wdata = $urandom;
      #1;
      chk("rd_addr_ok", 32'(addr_ok), 32'd1);
      chk("rd_idle_data_ok", 32'(data_ok), 32'd0);
      tick();
      if (!keep) req = 1'b0;
      for (int c = 0; c <= ard; c++) begin
         arready = (c == ard);
         #1;
         chk("rd_arvalid", 32'(arvalid), 32'd1);
         chk("rd_araddr", araddr, a);
         chk("rd_arsize", 32'(arsize), 32'(sz));
         chk("rd_a_addr_ok", 32'(addr_ok), 32'd0);
         chk("rd_a_data_ok", 32'(data_ok), 32'd0);
         chk("rd_a_rready", 32'(rready), 32'd0);
         tick();
      end
      arready = 1'b0;
      for (int c = 0; c <= rd; c++) begin
         rvalid    = (c == rd);
         axi_rdata = (c == rd) ? d : $urandom;
         #1;
         chk("rd_rready", 32'(rready), 32'd1);
         chk("rd_d_arvalid", 32'(arvalid), 32'd0);
         chk("rd_d_data_ok", 32'(data_ok), 32'd0);
         chk("rd_d_rdata_hold", rdata, exp_rdata);
         tick();
      end
      rvalid = 1'b0;
      #1;
      exp_rdata = d;
      chk("rd_data_ok", 32'(data_ok), 32'd1);
      chk("rd_rdata", rdata, exp_rdata);
      chk("rd_done_addr_ok", 32'(addr_ok), 32'd0);
      chk("rd_done_rready", 32'(rready), 32'd0);
      tick();
   endtask

   // Write with awd/wd cycles before each channel's ready and bd before bvalid.
   task automatic do_write(input logic [31:0] a, input logic [2:0] sz, input logic [3:0] strb,
                           input logic [31:0] d, input int awd, input int wd, input int bd,
                           input bit keep);
      int n;
      req = 1'b1; wr = 1'b1; addr = a; size = sz; wstrb = strb; wdata = d;
      #1;
      chk("wr_addr_ok", 32'(addr_ok), 32'd1);
      chk("wr_idle_data_ok", 32'(data_ok), 32'd0);
      tick();
      if (!keep) req = 1'b0;
      wdata = $urandom;
      addr  = $urandom;
      n = (awd > wd) ? awd : wd;
      for (int c = 0; c <= n; c++) begin
         awready = (c == awd);
         wready  = (c == wd);
         #1;
         chk("wr_awvalid", 32'(awvalid), (c <= awd) ? 32'd1 : 32'd0);
         chk("wr_wvalid", 32'(wvalid), (c <= wd) ? 32'd1 : 32'd0);
         if (c <= awd) begin
            chk("wr_awaddr", awaddr, a);
            chk("wr_awsize", 32'(awsize), 32'(sz));
         end
         if (c <= wd) begin
            chk("wr_wdata", axi_wdata, d);
            chk("wr_wstrb", 32'(axi_wstrb), 32'(strb));
         end
         chk("wr_a_bready", 32'(bready), 32'd0);
         chk("wr_a_data_ok", 32'(data_ok), 32'd0);
         chk("wr_a_addr_ok", 32'(addr_ok), 32'd0);
         tick();
      end
      awready = 1'b0;
      wready  = 1'b0;
      for (int c = 0; c <= bd; c++) begin
         bvalid = (c == bd);
         #1;
         chk("wr_bready", 32'(bready), 32'd1);
         chk("wr_b_awvalid", 32'(awvalid), 32'd0);
         chk("wr_b_wvalid", 32'(wvalid), 32'd0);
         chk("wr_b_data_ok", 32'(data_ok), 32'd0);
         tick();
      end
      bvalid = 1'b0;
      #1;
      chk("wr_data_ok", 32'(data_ok), 32'd1);
      chk("wr_rdata_kept", rdata, exp_rdata);
      chk("wr_done_addr_ok", 32'(addr_ok), 32'd0);
      chk("wr_done_bready", 32'(bready), 32'd0);
      tick();
   endtask

   initial begin
      n_tests = 0; n_fail = 0; exp_rdata = 32'd0;
      resetn = 1'b0; req = 1'b0; wr = 1'b0; size = 3'd0; wstrb = 4'd0;
      addr = 32'd0; wdata = 32'd0; arready = 1'b0; axi_rdata = 32'd0; rvalid = 1'b0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
      #1;
      chk("rst_addr_ok", 32'(addr_ok), 32'd0);
      chk("rst_data_ok", 32'(data_ok), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_valids", {28'd0, arvalid, awvalid, wvalid, 1'b0}, 32'd0);
      chk("rst_readys", {30'd0, rready, bready}, 32'd0);

      // Directed cases
      do_read(32'h1FC0_0010, 3'd2, 32'hDEAD_BEEF, 0, 0, 1'b0);
      do_write(32'h0000_0008, 3'd2, 4'h3, 32'h0000_1234, 0, 1, 0, 1'b0);
      do_write(32'h0000_0100, 3'd1, 4'hC, 32'hA5A5_5A5A, 0, 0, 2, 1'b0);
      do_write(32'h0000_0200, 3'd0, 4'h1, 32'h0000_00FF, 2, 0, 1, 1'b0);
      do_read(32'h1FC0_0020, 3'd2, 32'h0BAD_F00D, 5, 0, 1'b0);
      do_read(32'h0000_0040, 3'd2, 32'h1357_9BDF, 0, 2, 1'b1);
      do_write(32'h0000_0044, 3'd2, 4'hF, 32'h2468_ACE0, 0, 0, 0, 1'b0);

      // Reset while waiting for read data abandons the transaction
      req = 1'b1; wr = 1'b0; addr = 32'h0000_0080; size = 3'd2;
      #1;
      chk("mid_addr_ok", 32'(addr_ok), 32'd1);
      tick();
      req = 1'b0; arready = 1'b1;
      tick();
      arready = 1'b0; rvalid = 1'b1; axi_rdata = 32'hCAFE_F00D; resetn = 1'b0;
      tick();
      resetn = 1'b1; rvalid = 1'b0;
      exp_rdata = 32'd0;
      #1;
      chk("mid_rst_data_ok", 32'(data_ok), 32'd0);
      chk("mid_rst_rdata", rdata, 32'd0);
      chk("mid_rst_valids", {28'd0, arvalid, awvalid, wvalid, 1'b0}, 32'd0);
      chk("mid_rst_readys", {30'd0, rready, bready}, 32'd0);
      do_read(32'h0000_0090, 3'd2, 32'h7777_1111, 0, 0, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         logic [31:0] ra;
         logic [31:0] rd_d;
         logic [2:0]  rsz;
         logic [3:0]  rstrb;
         bit          keep;
         ra    = $urandom & 32'hFFFF_FFFC;
         rd_d  = $urandom;
         rsz   = 3'($urandom_range(0, 2));
         rstrb = 4'($urandom);
         keep  = (i != 39) && ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 1) == 1)
            do_write(ra, rsz, rstrb, rd_d, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), keep);
         else
            do_read(ra, rsz, rd_d, $urandom_range(0, 3), $urandom_range(0, 3), keep);
      end
      req = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/data_axi_bridge.md
Name: data_axi_bridge

Overview:
- Responder for the core's data-side request interface (req/wr/size/wstrb/addr/wdata with addr_ok/data_ok/rdata).
- Converts each accepted request into a single-beat AXI read or write, and returns completion on data_ok.
- Sits between the core's data port and the top-level AXI wrapper. Used for uncached accesses and as the cache-less data path.
- One transaction outstanding at a time; responses are returned in order.

Parameters:
- none; all address and data widths are fixed at 32.

Ports:
clk  in  1  clock
resetn  in  1  synchronous reset, active-low
req  in  1  core request valid
wr  in  1  1 = write, 0 = read
size  in  3  access size: 0 = byte, 1 = half, 2 = word
wstrb  in  4  write byte enables
addr  in  32  physical address
wdata  in  32  write data
addr_ok  out  1  request accepted this cycle
data_ok  out  1  one-cycle completion pulse
rdata  out  32  read data, valid while data_ok=1
araddr  out  32  AXI read address
arsize  out  3  AXI read size
arvalid  out  1  AXI read address valid
arready  in  1  AXI read address ready
axi_rdata  in  32  AXI read data
rvalid  in  1  AXI read data valid
rready  out  1  AXI read data ready
awaddr  out  32  AXI write address
awsize  out  3  AXI write size
awvalid  out  1  AXI write address valid
awready  in  1  AXI write address ready
axi_wdata  out  32  AXI write data
axi_wstrb  out  4  AXI write strobes
wvalid  out  1  AXI write data valid
wready  in  1  AXI write data ready
bvalid  in  1  AXI write response valid
bready  out  1  AXI write response ready

Behaviour:
- Reset (resetn=0 at a clock edge): state=IDLE; addr_ok=0, data_ok=0, rdata=0; all AXI valid/ready outputs=0; latched request regs=0. Reset mid-transaction abandons it; no data_ok is produced.
- Outputs not exposed here are fixed by the wrapper: len=0, burst=INCR, last=1, id=0.
- addr_ok = (state==IDLE) && req, combinational. On that edge, latch wr, size, wstrb, addr, wdata.
- States and transitions:
  - IDLE: on handshake, go to RD_A if wr=0, else WR_A.
  - RD_A: arvalid=1, araddr/arsize from latched regs. On arvalid&&arready go to RD_D.
  - RD_D: rready=1. On rvalid, register axi_rdata into rdata and go to DONE.
  - WR_A: awvalid and wvalid raised together. Per-channel done flags track completion in either order or the same cycle. Each valid drops after its own handshake. When both are done, go to WR_B.
  - WR_B: bready=1. On bvalid go to DONE.
  - DONE: data_ok=1 for exactly one cycle; next state IDLE. addr_ok=0 in DONE.
- Minimum latency with AXI ready/valid asserted immediately: read data_ok is 3 cycles after the addr_ok edge; write data_ok is 3 cycles after it.
- rdata holds its value until the next read completes. Write completion leaves rdata unchanged.
- Valid outputs never drop before their handshake. Address and data stay stable while valid is high.
- rresp and bresp are ignored.
- req held high during a transaction is not accepted until IDLE, so back-to-back throughput is one transaction per 4 cycles minimum.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, RD_A, RD_D, WR_A, WR_B, DONE);
  - size codes (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2);
  - AXI constants (LEN_SINGLE=0, BURST_INCR=1).
- Single flat module; no sub-module is warranted.

Test Plan:
- Read, AXI always ready: req=1, wr=0, addr=0x1FC0_0010, size=2 -> arvalid 1 cycle after addr_ok, araddr=0x1FC0_0010, arsize=2. Return rdata=0xDEADBEEF -> data_ok=1 and rdata=0xDEADBEEF 3 cycles after addr_ok.
- Write, awready one cycle before wready: addr=0x8, wstrb=0x3, wdata=0x1234 -> awvalid drops after its handshake while wvalid stays until wready. bready rises only after both handshakes. data_ok pulses once, 1 cycle after bvalid.
- Write, awready and wready in the same cycle -> go directly to WR_B; no duplicate handshake on either channel.
- Backpressure: arready held 0 for 5 cycles -> arvalid and araddr stable throughout, addr_ok=0, data_ok=0. Completion follows normally after arready=1.
- Back-to-back: req held high with read then write -> second addr_ok only in the cycle after the first data_ok. rdata keeps its read value through the write.
- Reset in RD_D (resetn=0 for 1 cycle) -> all outputs 0, state IDLE, no data_ok. A new request is accepted on the first cycle after reset is released.
